// File: rtl/regfile_dump_pkg.sv
// Shared types and defaults for the register-file dump engine.
package regfile_dump_pkg;

    localparam int DW_DEFAULT    = 64;
    localparam int AW_DEFAULT    = 5;
    localparam int NREGS_DEFAULT = 32;
    localparam int XZR_IDX       = 31;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        READ,
        SEND,
        DONE
    } state_t;

    function automatic int last_index(input int nregs, input bit include_xzr);
        return include_xzr ? nregs - 1 : nregs - 2;
    endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Beat stream from the dump engine: {index, value} under valid/ready.
interface regfile_dump_if #(
    parameter int DW = 64,
    parameter int AW = 5
) ();

    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;

    modport master (output out_valid, output out_idx, output out_data, input out_ready);
    modport slave  (input out_valid, input out_idx, input out_data, output out_ready);

endinterface

// File: rtl/regfile_dump_out_stage.sv
// Output holding register: keeps a beat stable until the sink takes it.
module regfile_dump_out_stage #(
    parameter int DW = 64,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          load,
    input  logic [AW-1:0] load_idx,
    input  logic [DW-1:0] load_data,
    output logic          accept,
    regfile_dump_if.master out
);

    logic          valid_q;
    logic [AW-1:0] idx_q;
    logic [DW-1:0] data_q;

    // flush has priority so an abort in READ never raises valid
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            idx_q   <= load_idx;
            data_q  <= load_data;
        end else if (accept) begin
            valid_q <= 1'b0;
        end
    end

    assign out.out_valid = valid_q;
    assign out.out_idx   = idx_q;
    assign out.out_data  = data_q;
    assign accept        = valid_q && out.out_ready;

endmodule

// File: rtl/regfile_dump.sv
// Debug dump engine: freezes the datapath and streams X0..X30 (+XZR) with an XOR checksum.
//  state    | meaning
//  IDLE     | waiting for start, stall low
//  WAIT_ACK | stall raised, waiting for the datapath to freeze
//  READ     | ra driven with idx, beat captured from rd at the edge
//  SEND     | beat offered on the stream until accepted
//  DONE     | one-cycle done pulse, stall dropped at the edge
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int AW          = AW_DEFAULT,
    parameter int NREGS       = NREGS_DEFAULT,
    parameter bit INCLUDE_XZR = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          stall_ack,
    input  logic          we3_mon,
    input  logic [DW-1:0] rd,
    output logic [AW-1:0] ra,
    output logic          stall,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] xsum,
    output logic          err,
    regfile_dump_if.master out
);

    localparam logic [AW-1:0] LAST = AW'(last_index(NREGS, INCLUDE_XZR));
    localparam logic [AW-1:0] XZR  = AW'(NREGS - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] idx;
    logic          accept;
    logic          load;
    logic          flush;
    logic          kick;
    logic          beat_taken;
    logic [DW-1:0] load_data;

    assign kick       = (state == IDLE) && start;
    assign flush      = abort && (state != IDLE);
    assign beat_taken = accept && !abort;
    assign load_data  = (idx == XZR) ? '0 : rd;
    assign busy       = (state != IDLE);
    assign stall      = busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ra        = '0;
        load      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (stall_ack) state_nxt = READ;
            end
            READ: begin
                // XZR is a constant, so the file never sees its address
                if (idx != XZR) ra = idx;
                load      = !abort;
                state_nxt = SEND;
            end
            SEND: begin
                if (accept) state_nxt = (idx == LAST) ? DONE : READ;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx  <= '0;
            xsum <= '0;
            err  <= 1'b0;
        end else begin
            if (kick) begin
                idx  <= '0;
                xsum <= '0;
            end else if (beat_taken) begin
                xsum <= xsum ^ out.out_data;
                if (idx != LAST) idx <= idx + AW'(1);
            end
            if (kick) begin
                err <= 1'b0;
            end else if (busy && stall_ack && we3_mon) begin
                err <= 1'b1;
            end
        end
    end

    regfile_dump_out_stage #(
        .DW(DW),
        .AW(AW)
    ) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .load      (load),
        .load_idx  (idx),
        .load_data (load_data),
        .accept    (accept),
        .out       (out)
    );

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: two instances (with and without XZR) against a regfile array model.
module tb_regfile_dump;

    localparam int BUDGET = 1000;

    logic        clk = 1'b0;
    logic        reset, start, abort, stall_ack, we3_mon, ready;
    logic [4:0]  ra_w   [2];
    logic [63:0] rd_w   [2];
    logic [63:0] xsum_w [2];
    logic        stall_w[2], busy_w[2], done_w[2], err_w[2], valid_w[2];
    logic [4:0]  idx_w  [2];
    logic [63:0] data_w [2];
    logic [63:0] regs   [32];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          got_n    [2];
    int          done_cnt [2];
    bit          ra31     [2];
    logic [4:0]  got_idx  [2][64];
    logic [63:0] got_data [2][64];
    bit          hold_q   [2];
    logic [4:0]  hold_idx [2];
    logic [63:0] hold_data[2];

    regfile_dump_if #(.DW(64), .AW(5)) if_a ();
    regfile_dump_if #(.DW(64), .AW(5)) if_b ();

    regfile_dump #(.DW(64), .AW(5), .NREGS(32), .INCLUDE_XZR(1'b1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .stall_ack(stall_ack),
        .we3_mon(we3_mon), .rd(rd_w[0]), .ra(ra_w[0]), .stall(stall_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .xsum(xsum_w[0]), .err(err_w[0]), .out(if_a)
    );

    regfile_dump #(.DW(64), .AW(5), .NREGS(32), .INCLUDE_XZR(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .stall_ack(stall_ack),
        .we3_mon(we3_mon), .rd(rd_w[1]), .ra(ra_w[1]), .stall(stall_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .xsum(xsum_w[1]), .err(err_w[1]), .out(if_b)
    );

    assign if_a.out_ready = ready;
    assign if_b.out_ready = ready;
    assign valid_w[0] = if_a.out_valid;
    assign idx_w[0]   = if_a.out_idx;
    assign data_w[0]  = if_a.out_data;
    assign valid_w[1] = if_b.out_valid;
    assign idx_w[1]   = if_b.out_idx;
    assign data_w[1]  = if_b.out_data;
    assign rd_w[0]    = regs[ra_w[0]];
    assign rd_w[1]    = regs[ra_w[1]];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat monitor: a beat counts when valid&&ready and neither abort nor reset wins the edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (start && !busy_w[d]) begin
                got_n[d]    = 0;
                done_cnt[d] = 0;
                ra31[d]     = 1'b0;
            end
            if (ra_w[d] == 5'd31) ra31[d] = 1'b1;
            if (done_w[d]) done_cnt[d]++;
            if (hold_q[d]) begin
                check("hold_valid", valid_w[d], 1'b1);
                check("hold_idx", idx_w[d], hold_idx[d]);
                check("hold_data", data_w[d], hold_data[d]);
            end
            if (valid_w[d] && ready && !abort && !reset && got_n[d] < 64) begin
                got_idx[d][got_n[d]]  = idx_w[d];
                got_data[d][got_n[d]] = data_w[d];
                got_n[d]++;
            end
            hold_q[d]    = valid_w[d] && !ready && !abort && !reset;
            hold_idx[d]  = idx_w[d];
            hold_data[d] = data_w[d];
        end
    end

    function automatic logic [63:0] xor_upto(input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) begin
            if (i != 31) r ^= regs[i];
        end
        return r;
    endfunction

    task automatic load_regs(input bit rnd);
        for (int i = 0; i < 31; i++) regs[i] = rnd ? {$urandom, $urandom} : 64'(i);
        regs[31] = {$urandom, $urandom} | 64'h1;
    endtask

    task automatic compare_dump(input int d);
        int nexp = (d == 0) ? 32 : 31;
        check(d == 0 ? "a_beat_count" : "b_beat_count", got_n[d], nexp);
        for (int i = 0; i < nexp && i < got_n[d]; i++) begin
            check(d == 0 ? "a_beat_idx" : "b_beat_idx", got_idx[d][i], i);
            check(d == 0 ? "a_beat_data" : "b_beat_data", got_data[d][i], (i == 31) ? 64'h0 : regs[i]);
        end
        check(d == 0 ? "a_xsum" : "b_xsum", xsum_w[d], xor_upto(nexp));
        check(d == 0 ? "a_done_once" : "b_done_once", done_cnt[d], 1);
        check(d == 0 ? "a_ra31" : "b_ra31", ra31[d], 1'b0);
    endtask

    task automatic check_zero(input int d);
        check("zero_ra", ra_w[d], 0);
        check("zero_stall", stall_w[d], 0);
        check("zero_busy", busy_w[d], 0);
        check("zero_valid", valid_w[d], 0);
        check("zero_idx", idx_w[d], 0);
        check("zero_data", data_w[d], 0);
        check("zero_done", done_w[d], 0);
        check("zero_xsum", xsum_w[d], 0);
        check("zero_err", err_w[d], 0);
    endtask

    // Index arguments of -1 disable the corresponding injection.
    task automatic run_dump(input int mode, input int ack_dly, input int err_at, input int start_at,
                            input int abort_at, input int reset_at, output int t_a, output int t_b);
        int hold = 0;
        bit tog  = 1'b1;
        bit stop = 1'b0;
        t_a = -1;
        t_b = -1;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (ack_dly) tick();
        check("wait_stall", stall_w[0], 1'b1);
        check("wait_valid", valid_w[0], 1'b0);
        stall_ack = 1'b1;
        for (int t = 1; t <= BUDGET && !stop; t++) begin
            if (mode == 1) begin
                if (hold > 0) begin
                    ready = 1'b0;
                    hold--;
                end else begin
                    ready = tog;
                    tog   = !tog;
                    if ($urandom_range(0, 3) == 0) hold = $urandom_range(0, 3);
                end
            end else begin
                ready = 1'b1;
            end
            we3_mon = valid_w[0] && (int'(idx_w[0]) == err_at);
            start   = valid_w[0] && (int'(idx_w[0]) == start_at);
            abort   = valid_w[0] && (int'(idx_w[0]) == abort_at);
            reset   = valid_w[0] && (int'(idx_w[0]) == reset_at);
            tick();
            if (start) begin
                check("start_ignored_xsum", xsum_w[0], xor_upto(start_at + 1));
                check("start_ignored_busy", busy_w[0], 1'b1);
            end
            if (abort || reset) stop = 1'b1;
            we3_mon = 1'b0;
            start   = 1'b0;
            abort   = 1'b0;
            reset   = 1'b0;
            if (done_w[1] && t_b < 0) t_b = t;
            if (done_w[0]) begin
                t_a  = t;
                stop = 1'b1;
            end
        end
        stall_ack = 1'b0;
        ready     = 1'b1;
        if (abort_at < 0 && reset_at < 0) check("dump_timeout", t_a > 0, 1'b1);
    endtask

    initial begin
        int t_a, t_b;
        reset = 1'b1; start = 1'b0; abort = 1'b0; stall_ack = 1'b0; we3_mon = 1'b0; ready = 1'b1;
        load_regs(1'b0);
        repeat (3) tick();
        check_zero(0);
        check_zero(1);
        reset = 1'b0;
        tick();
        we3_mon = 1'b1;
        stall_ack = 1'b1;
        tick();
        we3_mon = 1'b0;
        stall_ack = 1'b0;
        check("err_idle", err_w[0], 1'b0);

        // Full dump, ready tied high: Xi = i so both checksums are XOR(0..30).
        run_dump(0, 3, -1, -1, -1, -1, t_a, t_b);
        check("cycles_a", t_a, 2 * 32 + 1);
        check("cycles_b", t_b, 2 * 31 + 1);
        tick();
        check("stall_after_done", stall_w[0], 1'b0);
        check("busy_after_done", busy_w[0], 1'b0);
        check("xsum_a_1f", xsum_w[0], 64'h1f);
        check("xsum_b_1f", xsum_w[1], 64'h1f);
        compare_dump(0);
        compare_dump(1);

        // Random contents with a toggling, randomly stalled sink.
        load_regs(1'b1);
        run_dump(1, $urandom_range(0, 5), -1, -1, -1, -1, t_a, t_b);
        tick();
        compare_dump(0);
        compare_dump(1);

        // Abort wins over the accept of beat 10.
        load_regs(1'b0);
        run_dump(0, 2, -1, -1, 10, -1, t_a, t_b);
        check("abort_busy", busy_w[0], 1'b0);
        check("abort_stall", stall_w[0], 1'b0);
        check("abort_valid", valid_w[0], 1'b0);
        check("abort_xsum", xsum_w[0], 64'h1);
        check("abort_beats", got_n[0], 10);
        check("abort_busy_b", busy_w[1], 1'b0);
        repeat (3) tick();
        check("abort_no_done", done_cnt[0], 0);

        // Write seen while frozen sets a sticky error that the next start clears.
        load_regs(1'b1);
        run_dump(0, 1, 7, -1, -1, -1, t_a, t_b);
        tick();
        check("err_sticky_a", err_w[0], 1'b1);
        check("err_sticky_b", err_w[1], 1'b1);
        compare_dump(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_cleared", err_w[0], 1'b0);
        check("xsum_cleared", xsum_w[0], 64'h0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_wait_busy", busy_w[0], 1'b0);

        // start during SEND is ignored; reset at beat 5 returns everything to zero.
        load_regs(1'b1);
        run_dump(0, 2, -1, 3, -1, 5, t_a, t_b);
        check("reset_beats", got_n[0], 5);
        check_zero(0);
        check_zero(1);

        load_regs(1'b1);
        run_dump(1, 0, -1, -1, -1, -1, t_a, t_b);
        tick();
        compare_dump(0);
        compare_dump(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
